serial_adder_n: RTL and testbench



---
 rtl/serial_adder_n.sv | 155 +++++++++++++++
 tb/tb_serial_adder_n.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_n.sv
// serial_adder_n: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, through a registered carry chain with valid/ready on both sides.
// Optional build macro SERIAL_ADDER_N_SUB_EN adds a 'sub' input selecting
// a + ~b + 1 (cout=1 means no borrow).
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready=1
// S_RUN  | adding one digit per cycle, NDIG cycles
// S_DONE | result presented, waiting for out_ready
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_N_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [DIGIT:0]   w_add;
  logic [DIGIT-1:0] w_d;
  logic             w_c;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;
  logic [WIDTH-1:0] w_b_cap;
  logic             w_carry_cap;

  // Full DIGIT+1 bit digit sum so the carry is never truncated away.
  assign w_add  = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, r_carry};
  assign w_d    = w_add[DIGIT-1:0];
  assign w_c    = w_add[DIGIT];
  assign w_last = (r_cnt == CW'(NDIG - 1));

`ifdef SERIAL_ADDER_N_SUB_EN
  // Subtraction is a + ~b + 1: invert b at capture and seed the carry with 1.
  assign w_b_cap     = sub ? ~b : b;
  assign w_carry_cap = sub ? 1'b1 : cin;
`else
  assign w_b_cap     = b;
  assign w_carry_cap = cin;
`endif

  // The partial-sum register only needs the digits finished so far; the
  // digit computed in the last RUN cycle goes straight into the output.
  if (NDIG > 1) begin : g_multi
    logic [WIDTH-DIGIT-1:0] r_sum_sh;

    assign w_sum_next = {w_d, r_sum_sh};

    // Partial sum shifts right by one digit each RUN cycle, new digit on top.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum_sh <= '0;
      end else if (r_state == S_IDLE && in_valid) begin
        r_sum_sh <= '0;
      end else if (r_state == S_RUN) begin
        r_sum_sh <= w_sum_next[WIDTH-1:DIGIT];
      end
    end
  end else begin : g_single
    assign w_sum_next = w_d;
  end

  // Control FSM, operand shifters, carry chain and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh     <= a;
            r_b_sh     <= w_b_cap;
            r_carry    <= w_carry_cap;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_a_sh  <= r_a_sh >> DIGIT;
          r_b_sh  <= r_b_sh >> DIGIT;
          r_carry <= w_c;
          if (w_last) begin
            r_sum       <= w_sum_next;
            r_cout      <= w_c;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: scoreboard bench for serial_adder_n, DIGIT=1 and DIGIT=4.
module tb_serial_adder_n;

  logic       clk;
  logic       rst;

  logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [7:0] a1, b1, sum1;
  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [7:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_N_SUB_EN
  logic       sub1, sub4;
`endif

  logic [8:0] q1[$];
  logic [8:0] q4[$];
  logic [8:0] e1, e4;
  int         total = 0;
  int         bad   = 0;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_N_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_N_SUB_EN
    .sub(sub4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic cv, input logic sv);
    if (sv) return {1'b0, av} + {1'b0, ~bv} + 9'd1;
    return {1'b0, av} + {1'b0, bv} + {8'd0, cv};
  endfunction

  // Scoreboard monitors: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid1 && out_ready1) begin
      if (q1.size() == 0) chk("unexpected_out1", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("result1", {23'd0, cout1, sum1}, {23'd0, e1});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (q4.size() == 0) chk("unexpected_out4", 1, 0);
      else begin
        e4 = q4.pop_front();
        chk("result4", {23'd0, cout4, sum4}, {23'd0, e4});
      end
    end
  end

  task automatic send1(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic sv, input logic [8:0] exp, input int hold);
    int n;
    n = 0;
    while (!in_ready1 && n < 50) begin tick(); n++; end
    chk("ready_wait1", {31'd0, in_ready1}, 1);
    out_ready1 = (hold == 0);
    a1 = av; b1 = bv; cin1 = cv; in_valid1 = 1'b1;
`ifdef SERIAL_ADDER_N_SUB_EN
    sub1 = sv;
`endif
    q1.push_back(exp);
    tick();
    in_valid1 = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom); cin1 = 1'($urandom);
    n = 0;
    while (!out_valid1 && n < 100) begin
      chk("in_ready_run1", {31'd0, in_ready1}, 0);
      chk("busy_run1", {31'd0, busy1}, 1);
      tick();
      n++;
    end
    chk("latency1", n, 8);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid1", {31'd0, out_valid1}, 1);
      chk("hold_sum1", {23'd0, cout1, sum1}, {23'd0, exp});
      chk("hold_in_ready1", {31'd0, in_ready1}, 0);
      tick();
    end
    out_ready1 = 1'b1;
    tick();
    chk("valid_drop1", {31'd0, out_valid1}, 0);
    chk("ready_back1", {31'd0, in_ready1}, 1);
  endtask

  task automatic send4(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                       input logic sv, input logic [8:0] exp);
    int n;
    n = 0;
    while (!in_ready4 && n < 50) begin tick(); n++; end
    chk("ready_wait4", {31'd0, in_ready4}, 1);
    a4 = av; b4 = bv; cin4 = cv; in_valid4 = 1'b1;
`ifdef SERIAL_ADDER_N_SUB_EN
    sub4 = sv;
`endif
    q4.push_back(exp);
    tick();
    in_valid4 = 1'b0;
    a4 = 8'($urandom); b4 = 8'($urandom);
    n = 0;
    while (!out_valid4 && n < 100) begin
      chk("in_ready_run4", {31'd0, in_ready4}, 0);
      tick();
      n++;
    end
    chk("latency4", n, 2);
    tick();
    chk("valid_drop4", {31'd0, out_valid4}, 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc, rs;
    int         n;
    rst = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b1;
`ifdef SERIAL_ADDER_N_SUB_EN
    sub1 = 1'b0; sub4 = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_in_ready", {31'd0, in_ready1}, 1);
    chk("rst_out_valid", {31'd0, out_valid1}, 0);
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_sum", {23'd0, cout1, sum1}, 0);
    rst = 1'b0;
    tick();

    send1(8'h00, 8'h00, 1'b0, 1'b0, 9'h000, 0);
    send1(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 0);
    send1(8'hA5, 8'h5A, 1'b1, 1'b0, 9'h100, 0);
    send1(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 0);
    send1(8'h3C, 8'h0F, 1'b0, 1'b0, 9'h04B, 5);

    // Abort in RUN: no result may ever appear for this pair.
    a1 = 8'h12; b1 = 8'h34; cin1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_run_ready", {31'd0, in_ready1}, 1);
    chk("abort_run_busy", {31'd0, busy1}, 0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_run_novalid", {31'd0, out_valid1}, 0);
      tick();
    end
    send1(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, 0);

    // Abort in DONE while the consumer stalls.
    out_ready1 = 1'b0;
    a1 = 8'h55; b1 = 8'h11; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 100) begin tick(); n++; end
    chk("abort_done_reached", {31'd0, out_valid1}, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_done_valid", {31'd0, out_valid1}, 0);
    chk("abort_done_ready", {31'd0, in_ready1}, 1);
    out_ready1 = 1'b1;
    tick();

`ifdef SERIAL_ADDER_N_SUB_EN
    send1(8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE, 0);
    send1(8'h07, 8'h05, 1'b1, 1'b1, 9'h102, 0);
    send4(8'h05, 8'h07, 1'b1, 1'b1, 9'h0FE);
`endif

    for (int i = 0; i < 100; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_N_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      send1(ra, rb, rc, rs, model(ra, rb, rc, rs), 0);
    end

    send4(8'h9C, 8'h78, 1'b0, 1'b0, 9'h114);
    send4(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF);
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_N_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      send4(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    repeat (3) tick();
    chk("queue1_empty", q1.size(), 0);
    chk("queue4_empty", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
